// File: rtl/shift_seq_if.sv
// Request/response handshake bundle for shift_seq.
// master = requester side, slave = sequencer side.
interface shift_seq_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [AMT_W-1:0] req_amt;
  logic             req_dir;
  logic [1:0]       req_type;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_data, req_amt,
    output req_dir, req_type, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_amt,
    input  req_dir, req_type, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-pass sequencer in front of a combinational barrel shifter.
// SHIFT_SEQ_BACK2BACK_EN: accept a new request in DONE without an IDLE bubble.
module shift_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  shift_seq_if.slave               bus,
  output logic                     busy,
  output logic [WIDTH-1:0]         sh_in,
  output logic [$clog2(WIDTH)-1:0] sh_ct,
  output logic                     sh_dir,
  output logic [1:0]               sh_type,
  input  logic [WIDTH-1:0]         sh_out
);
  localparam int CT_W = $clog2(WIDTH);

  localparam logic [AMT_W:0] FULL = (AMT_W+1)'(WIDTH);
  localparam logic [AMT_W:0] MAXP = (AMT_W+1)'(WIDTH-1);

  localparam logic [1:0] T_NS = 2'd0;
  localparam logic [1:0] T_LO = 2'd1;
  localparam logic [1:0] T_AR = 2'd2;
  localparam logic [1:0] T_RO = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [AMT_W:0]   rem, rem_n;
  logic             dir_q, dir_n;
  logic [1:0]       type_q, type_n;

  logic [AMT_W:0]   eff;
  logic [AMT_W:0]   step;
  logic             req_ready;
  logic             rsp_valid;
  logic [CT_W-1:0]  ct;

  // Shifts past WIDTH cannot change a logical/arithmetic result.
  always_comb begin
    eff = '0;
    unique case (bus.req_type)
      T_NS: eff = '0;
      T_LO,
      T_AR: eff = ({1'b0, bus.req_amt} > FULL) ?
                  FULL : {1'b0, bus.req_amt};
      T_RO: eff = {1'b0, bus.req_amt} & MAXP;
      default: eff = '0;
    endcase
  end

  assign step = (rem > MAXP) ? MAXP : rem;

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    rem_n     = rem;
    dir_n     = dir_q;
    type_n    = type_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    ct        = '0;
    unique case (state)
      IDLE: req_ready = 1'b1;
      RUN: begin
        busy  = 1'b1;
        ct    = step[CT_W-1:0];
        acc_n = sh_out;
        rem_n = rem - step;
        if (rem == step) state_n = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
`ifdef SHIFT_SEQ_BACK2BACK_EN
        req_ready = bus.rsp_ready;
`else
        req_ready = 1'b0;
`endif
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (req_ready && bus.req_valid) begin
      acc_n   = bus.req_data;
      rem_n   = eff;
      dir_n   = bus.req_dir;
      type_n  = bus.req_type;
      state_n = (eff == '0) ? DONE : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      dir_q  <= 1'b0;
      type_q <= '0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      rem    <= rem_n;
      dir_q  <= dir_n;
      type_q <= type_n;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = acc;
  assign sh_in         = acc;
  assign sh_ct         = ct;
  assign sh_dir        = dir_q;
  assign sh_type       = type_q;
endmodule
